// File: rtl/keycode_evt_pkg.sv
// Shared types for the keycode event queue: event record, no-key code and
// the typematic (auto-repeat) FSM state encoding.
package keycode_evt_pkg;

   localparam logic [7:0] KEY_NONE = 8'h00;

   // 'repeat' is a reserved word, hence is_repeat
   typedef struct packed {
      logic [7:0] code;
      logic       press;
      logic       is_repeat;
   } keycode_evt_t;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_t;

   function automatic keycode_evt_t mk_evt(input logic [7:0] code,
                                           input logic       press,
                                           input logic       is_repeat);
      keycode_evt_t e;
      e.code      = code;
      e.press     = press;
      e.is_repeat = is_repeat;
      return e;
   endfunction

endpackage

// File: rtl/keycode_evt_fifo.sv
// Show-ahead FIFO of keycode events. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is ignored.
module keycode_evt_fifo
   import keycode_evt_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push_i,
   input  keycode_evt_t             data_i,
   input  logic                     pop_i,
   output keycode_evt_t             data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   keycode_evt_t          mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           count_q, count_d;
   logic                  do_push, do_pop;

   always_comb begin
      empty_o  = (count_q == '0);
      full_o   = (count_q == (AW+1)'(DEPTH));
      do_pop   = pop_i && !empty_o;
      do_push  = push_i && (!full_o || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // DEPTH is a power of two, so pointer overflow is the modulo wrap
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      data_o  = mem_q[rd_ptr_q];
      level_o = count_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/keycode_event_queue.sv
// Turns the level keycode from the PIO into a queue of press/release events.
// Optional auto-repeat is enabled with the KEYCODE_REPEAT_EN macro.
module keycode_event_queue
   import keycode_evt_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE  = 5_000_000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [7:0]             keycode_i,
   output logic                   evt_valid_o,
   input  logic                   evt_ready_i,
   output logic [7:0]             evt_code_o,
   output logic                   evt_press_o,
   output logic                   evt_repeat_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   overflow_o,
   input  logic                   clear_ovf_i
);

   logic [7:0]   k_q, k_d;
   logic [7:0]   cur_q, cur_d;
   logic         ovf_q, ovf_d;
   logic         edge_evt, rpt_fire, push, pop, full, empty;
   keycode_evt_t edge_data, push_data, head;

   // Change engine: a key-to-key change is split into release then press,
   // so cur always passes through KEY_NONE between two keys.
   always_comb begin
      k_d       = keycode_i;
      edge_evt  = (k_q != cur_q);
      cur_d     = cur_q;
      edge_data = mk_evt(KEY_NONE, 1'b0, 1'b0);
      if (edge_evt) begin
         if (cur_q != KEY_NONE) begin
            edge_data = mk_evt(cur_q, 1'b0, 1'b0);
            cur_d     = KEY_NONE;
         end else begin
            edge_data = mk_evt(k_q, 1'b1, 1'b0);
            cur_d     = k_q;
         end
      end
      push      = edge_evt || rpt_fire;
      push_data = edge_evt ? edge_data : mk_evt(cur_q, 1'b1, 1'b1);
      pop       = !empty && evt_ready_i;
      // Only dropped edge events are sticky; a new drop beats the clear
      if (edge_evt && full && !pop) ovf_d = 1'b1;
      else if (clear_ovf_i)         ovf_d = 1'b0;
      else                          ovf_d = ovf_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         k_q   <= KEY_NONE;
         cur_q <= KEY_NONE;
         ovf_q <= 1'b0;
      end else begin
         k_q   <= k_d;
         cur_q <= cur_d;
         ovf_q <= ovf_d;
      end
   end

`ifdef KEYCODE_REPEAT_EN
   rpt_state_t  rpt_state_q, rpt_state_d;
   logic [31:0] rpt_cnt_q, rpt_cnt_d;

   // Edge events win over a due repeat; the timer restarts from the edge
   always_comb begin
      rpt_state_d = rpt_state_q;
      rpt_cnt_d   = rpt_cnt_q;
      rpt_fire    = 1'b0;
      if (edge_evt) begin
         if (cur_q == KEY_NONE) begin
            rpt_state_d = RPT_DELAY;
            rpt_cnt_d   = 32'(REPEAT_DELAY - 1);
         end else begin
            rpt_state_d = RPT_IDLE;
            rpt_cnt_d   = '0;
         end
      end else if (cur_q == KEY_NONE) begin
         rpt_state_d = RPT_IDLE;
         rpt_cnt_d   = '0;
      end else begin
         case (rpt_state_q)
            RPT_DELAY, RPT_REPEAT: begin
               if (rpt_cnt_q == '0) begin
                  rpt_fire    = 1'b1;
                  rpt_state_d = RPT_REPEAT;
                  rpt_cnt_d   = 32'(REPEAT_RATE - 1);
               end else begin
                  rpt_cnt_d   = rpt_cnt_q - 1'b1;
               end
            end
            default: begin
               rpt_state_d = RPT_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rpt_state_q <= RPT_IDLE;
         rpt_cnt_q   <= '0;
      end else begin
         rpt_state_q <= rpt_state_d;
         rpt_cnt_q   <= rpt_cnt_d;
      end
   end
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
   assign rpt_fire          = 1'b0;
`endif

   keycode_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level_o)
   );

   // Head fields are gated so outputs read 0 while the queue is empty
   always_comb begin
      evt_valid_o  = !empty;
      evt_code_o   = empty ? KEY_NONE : head.code;
      evt_press_o  = !empty && head.press;
`ifdef KEYCODE_REPEAT_EN
      evt_repeat_o = !empty && head.is_repeat;
`else
      evt_repeat_o = 1'b0;
`endif
      overflow_o   = ovf_q;
   end

endmodule

// File: tb/tb_keycode_event_queue.sv
// Directed bench for keycode_event_queue (DEPTH=4); the auto-repeat section
// runs only when KEYCODE_REPEAT_EN is defined.
module tb_keycode_event_queue;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [7:0]    keycode_i;
   logic          evt_valid_o;
   logic          evt_ready_i;
   logic [7:0]    evt_code_o;
   logic          evt_press_o;
   logic          evt_repeat_o;
   logic [LW-1:0] level_o;
   logic          overflow_o;
   logic          clear_ovf_i;

   int total = 0;
   int bad   = 0;

   keycode_event_queue #(
      .DEPTH        (DEPTH),
      .REPEAT_DELAY (10),
      .REPEAT_RATE  (4)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .keycode_i    (keycode_i),
      .evt_valid_o  (evt_valid_o),
      .evt_ready_i  (evt_ready_i),
      .evt_code_o   (evt_code_o),
      .evt_press_o  (evt_press_o),
      .evt_repeat_o (evt_repeat_o),
      .level_o      (level_o),
      .overflow_o   (overflow_o),
      .clear_ovf_i  (clear_ovf_i)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic [7:0] code, input logic press,
                           input logic rpt);
      chk({tag, ".valid"},  32'(evt_valid_o),  32'd1);
      chk({tag, ".code"},   32'(evt_code_o),   32'(code));
      chk({tag, ".press"},  32'(evt_press_o),  32'(press));
      chk({tag, ".repeat"}, 32'(evt_repeat_o), 32'(rpt));
   endtask

   initial begin
      logic [7:0] tog_code [6];
      logic       tog_press[6];
      reset_n     = 1'b0;
      keycode_i   = 8'h00;
      evt_ready_i = 1'b0;
      clear_ovf_i = 1'b0;
      #3;
      chk("rst.valid", 32'(evt_valid_o), 32'd0);
      chk("rst.level", 32'(level_o),     32'd0);
      chk("rst.ovf",   32'(overflow_o),  32'd0);
      chk("rst.code",  32'(evt_code_o),  32'd0);
      #9 reset_n = 1'b1;
      tick();

      // First press: visible after the second edge
      keycode_i = 8'h04;
      tick();
      chk("p1.e0.valid", 32'(evt_valid_o), 32'd0);
      tick();
      chk_head("p1", 8'h04, 1'b1, 1'b0);
      chk("p1.level", 32'(level_o), 32'd1);

      // 0x04 -> 0x05 with ready high
      keycode_i   = 8'h05;
      evt_ready_i = 1'b1;
      tick();
      chk("k2k.a.valid", 32'(evt_valid_o), 32'd0);
      tick();
      chk_head("k2k.rel4", 8'h04, 1'b0, 1'b0);
      tick();
      chk_head("k2k.prs5", 8'h05, 1'b1, 1'b0);
      chk("k2k.level1", 32'(level_o), 32'd1);
      tick();
      chk("k2k.drain.valid", 32'(evt_valid_o), 32'd0);
      chk("k2k.drain.level", 32'(level_o),     32'd0);

      // 0x05 -> 0x04 -> 0x05 one cycle apart: release 5, press 5 only
      evt_ready_i = 1'b0;
      keycode_i   = 8'h04;
      tick();
      keycode_i   = 8'h05;
      tick();
      tick();
      tick();
      tick();
      chk("aba.level", 32'(level_o), 32'd2);
      chk_head("aba.rel5", 8'h05, 1'b0, 1'b0);
      evt_ready_i = 1'b1;
      tick();
      chk_head("aba.prs5", 8'h05, 1'b1, 1'b0);
      tick();
      chk("aba.empty", 32'(evt_valid_o), 32'd0);

      // Return to no key and drain
      keycode_i = 8'h00;
      repeat (4) tick();
      evt_ready_i = 1'b0;
      chk("idle.level", 32'(level_o), 32'd0);

      // Six toggles into a 4-deep queue: two drops
      for (int i = 0; i < 6; i++) begin
         keycode_i = (i % 2 == 0) ? 8'h07 : 8'h00;
         tick();
         tick();
      end
      tick();
      tick();
      chk("ovf.level", 32'(level_o),    32'd4);
      chk("ovf.flag",  32'(overflow_o), 32'd1);
      clear_ovf_i = 1'b1;
      tick();
      clear_ovf_i = 1'b0;
      chk("ovf.clear", 32'(overflow_o), 32'd0);
      tog_code  = '{8'h07, 8'h07, 8'h07, 8'h07, 8'h00, 8'h00};
      tog_press = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      evt_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_head($sformatf("ovf.pop%0d", i), tog_code[i], tog_press[i], 1'b0);
         tick();
      end
      evt_ready_i = 1'b0;
      chk("ovf.empty", 32'(evt_valid_o), 32'd0);

      // Full queue with simultaneous push and pop
      for (int i = 0; i < 4; i++) begin
         keycode_i = (i % 2 == 0) ? 8'h07 : 8'h00;
         tick();
         tick();
      end
      tick();
      chk("fpp.full", 32'(level_o), 32'd4);
      keycode_i = 8'h09;
      tick();
      evt_ready_i = 1'b1;
      tick();
      evt_ready_i = 1'b0;
      chk("fpp.level", 32'(level_o),    32'd4);
      chk("fpp.ovf",   32'(overflow_o), 32'd0);
      chk_head("fpp.h0", 8'h07, 1'b0, 1'b0);
      evt_ready_i = 1'b1;
      tick();
      chk_head("fpp.h1", 8'h07, 1'b1, 1'b0);
      tick();
      chk_head("fpp.h2", 8'h07, 1'b0, 1'b0);
      tick();
      chk_head("fpp.h3", 8'h09, 1'b1, 1'b0);
      tick();
      chk("fpp.empty", 32'(evt_valid_o), 32'd0);
      evt_ready_i = 1'b0;

      // Reset mid-operation drops the pending release; held key re-presses
      keycode_i = 8'h00;
      tick();
      #2 reset_n = 1'b0;
      #1;
      chk("mrst.level", 32'(level_o),     32'd0);
      chk("mrst.valid", 32'(evt_valid_o), 32'd0);
      keycode_i = 8'h0A;
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      chk("mrst.e0.valid", 32'(evt_valid_o), 32'd0);
      tick();
      chk_head("mrst.press", 8'h0A, 1'b1, 1'b0);
      chk("mrst.level1", 32'(level_o), 32'd1);

`ifdef KEYCODE_REPEAT_EN
      // Hold 0x2C: repeats at +10, +14, +18; release lands at +22
      reset_n     = 1'b0;
      keycode_i   = 8'h00;
      #3;
      @(negedge clk);
      reset_n     = 1'b1;
      evt_ready_i = 1'b1;
      keycode_i   = 8'h2C;
      tick();
      tick();
      chk_head("rpt.first", 8'h2C, 1'b1, 1'b0);
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (k == 10 || k == 14 || k == 18)
            chk_head($sformatf("rpt.k%0d", k), 8'h2C, 1'b1, 1'b1);
         else if (k == 22)
            chk_head("rpt.release", 8'h2C, 1'b0, 1'b0);
         else
            chk($sformatf("rpt.quiet%0d", k), 32'(evt_valid_o), 32'd0);
         if (k == 20) keycode_i = 8'h00;
      end
      chk("rpt.ovf", 32'(overflow_o), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
